// File: rtl/layer_cmd_dispatch.sv
// layer_cmd_dispatch: reg0 command decoder and MM2S-to-buffer write steering.
// Optional DISPATCH_TKEEP_CHECK_EN drops partial-keep beats and flags cmd_err.
module layer_cmd_dispatch #(
  parameter int ADDR_W        = 12,
  parameter int FEATURE_DEPTH = 4096
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic [31:0]       slave_lite_reg0,
  input  logic [31:0]       slave_lite_reg1,
  input  logic [63:0]       s_axis_mm2s_tdata,
  input  logic [7:0]        s_axis_mm2s_tkeep,
  input  logic              s_axis_mm2s_tvalid,
  output logic              s_axis_mm2s_tready,
  input  logic              s_axis_mm2s_tlast,
  output logic              wr_en,
  output logic [3:0]        wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              conv_start,
  output logic              rx_start,
  output logic [7:0]        conv_rows,
  output logic              conv_final,
  input  logic              conv_done,
  input  logic              rx_done,
  output logic              task_finish,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CONV, RX, DONE
  } state_t;

  state_t state, state_n;

  logic [2:0]        cmd_q, cmd_edge;
  logic [3:0]        tgt_sel, sel;
  logic              tgt_ok, use_msb;
  logic              load_go, bad_go;
  logic              hs, keep_ok, feat_wrap;
  logic [ADDR_W-1:0] msb, base, ofs;
  logic [ADDR_W-1:0] feat_addr, cur_addr;
  logic              unused;

  assign cmd_edge = slave_lite_reg0[2:0] & ~cmd_q;
  assign msb      = {1'b1, {(ADDR_W-1){1'b0}}};

  always_comb begin
    tgt_sel = '0;
    case (slave_lite_reg0[7:4])
      4'd1:    tgt_sel = 4'b0100;
      4'd2:    tgt_sel = 4'b0001;
      4'd3:    tgt_sel = 4'b0010;
      4'd8:    tgt_sel = 4'b1000;
      default: tgt_sel = 4'b0000;
    endcase
  end

  assign tgt_ok  = |tgt_sel;
  assign use_msb = (tgt_sel[2] & slave_lite_reg1[8])
                 | (tgt_sel[0] & slave_lite_reg1[0]);
  assign load_go = (state == IDLE) && cmd_edge[0] && tgt_ok;
  assign bad_go  = (state == IDLE) && cmd_edge[0] && !tgt_ok;

  assign s_axis_mm2s_tready = (state == LOAD);
  assign hs = s_axis_mm2s_tvalid & s_axis_mm2s_tready;
  assign task_finish = (state == DONE);

`ifdef DISPATCH_TKEEP_CHECK_EN
  assign keep_ok = (s_axis_mm2s_tkeep == 8'hFF);
  assign unused  = ^{slave_lite_reg0[31:24], slave_lite_reg0[15:11],
                     slave_lite_reg0[8], slave_lite_reg0[3],
                     slave_lite_reg1[31:9], slave_lite_reg1[7:1]};
`else
  assign keep_ok = 1'b1;
  assign unused  = ^{slave_lite_reg0[31:24], slave_lite_reg0[15:11],
                     slave_lite_reg0[8], slave_lite_reg0[3],
                     slave_lite_reg1[31:9], slave_lite_reg1[7:1],
                     s_axis_mm2s_tkeep};
`endif

  assign feat_wrap = (feat_addr == ADDR_W'(FEATURE_DEPTH - 1));
  assign cur_addr  = sel[3] ? feat_addr : (base | ofs);

  always_ff @(posedge sclk) begin
    if (s_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (cmd_edge[0])      state_n = tgt_ok ? LOAD : DONE;
        else if (cmd_edge[2]) state_n = CONV;
        else if (cmd_edge[1]) state_n = RX;
      end
      LOAD:    if (hs && s_axis_mm2s_tlast) state_n = DONE;
      CONV:    if (conv_done) state_n = DONE;
      RX:      if (rx_done) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      cmd_q      <= '0;
      sel        <= '0;
      base       <= '0;
      ofs        <= '0;
      feat_addr  <= '0;
      wr_en      <= 1'b0;
      wr_sel     <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      conv_start <= 1'b0;
      rx_start   <= 1'b0;
      conv_rows  <= '0;
      conv_final <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_q      <= slave_lite_reg0[2:0];
      wr_en      <= 1'b0;
      conv_start <= (state == IDLE) && (state_n == CONV);
      rx_start   <= (state == IDLE) && (state_n == RX);
      if (load_go) begin
        sel  <= tgt_sel;
        base <= use_msb ? msb : '0;
        ofs  <= '0;
        if (tgt_sel[3]) begin
          conv_rows  <= slave_lite_reg0[23:16];
          conv_final <= slave_lite_reg0[10];
          if (!slave_lite_reg0[9]) feat_addr <= '0;
        end
      end
      if (bad_go) cmd_err <= 1'b1;
      // partial-keep beats are consumed but leave the address untouched
      if (hs) begin
        if (keep_ok) begin
          wr_en   <= 1'b1;
          wr_sel  <= sel;
          wr_addr <= cur_addr;
          wr_data <= s_axis_mm2s_tdata;
          if (sel[3])
            feat_addr <= feat_wrap ? '0 : feat_addr + ADDR_W'(1);
          else
            ofs <= ofs + ADDR_W'(1);
        end else begin
          cmd_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer_cmd_dispatch.sv
// tb_layer_cmd_dispatch: decode table, corner sequences and a
// randomized command stream checked against a write-list model.
module tb_layer_cmd_dispatch;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;

  logic          sclk = 1'b0;
  logic          s_rst;
  logic [31:0]   reg0, reg1;
  logic [63:0]   tdata;
  logic [7:0]    tkeep;
  logic          tvalid, tready, tlast;
  logic          wr_en;
  logic [3:0]    wr_sel;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          conv_start, rx_start;
  logic [7:0]    conv_rows;
  logic          conv_final;
  logic          conv_done, rx_done;
  logic          task_finish, cmd_err;

  int vecs = 0;
  int errs = 0;
  int feat_next = 0;
  int rows_m = 0;
  int final_m = 0;

  typedef struct {
    logic [31:0] r0;
    logic [31:0] r1;
    int          beats;
    logic [3:0]  sel;
    int          base;
    bit          err;
  } vec_t;

  vec_t tab[9];

  layer_cmd_dispatch #(.ADDR_W(AW), .FEATURE_DEPTH(DEPTH)) dut (
    .sclk(sclk), .s_rst(s_rst),
    .slave_lite_reg0(reg0), .slave_lite_reg1(reg1),
    .s_axis_mm2s_tdata(tdata), .s_axis_mm2s_tkeep(tkeep),
    .s_axis_mm2s_tvalid(tvalid), .s_axis_mm2s_tready(tready),
    .s_axis_mm2s_tlast(tlast),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .conv_start(conv_start), .rx_start(rx_start),
    .conv_rows(conv_rows), .conv_final(conv_final),
    .conv_done(conv_done), .rx_done(rx_done),
    .task_finish(task_finish), .cmd_err(cmd_err)
  );

  always #5 sclk = ~sclk;

  task automatic cyc();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tready"}, 64'(tready), 0);
    chk({tag, "_wr_en"}, 64'(wr_en), 0);
    chk({tag, "_wr_sel"}, 64'(wr_sel), 0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_conv_start"}, 64'(conv_start), 0);
    chk({tag, "_rx_start"}, 64'(rx_start), 0);
    chk({tag, "_conv_rows"}, 64'(conv_rows), 0);
    chk({tag, "_conv_final"}, 64'(conv_final), 0);
    chk({tag, "_finish"}, 64'(task_finish), 0);
    chk({tag, "_cmd_err"}, 64'(cmd_err), 0);
  endtask

  task automatic do_reset();
    s_rst = 1'b1;
    reg0 = '0;
    tvalid = 1'b0;
    tlast = 1'b0;
    conv_done = 1'b0;
    rx_done = 1'b0;
    cyc();
    chk_zero("rst");
    s_rst = 1'b0;
    feat_next = 0;
    rows_m = 0;
    final_m = 0;
  endtask

  task automatic pulse(input logic [31:0] v);
    reg0 = v;
    cyc();
    reg0 = v & ~32'h7;
  endtask

  // state must already be LOAD; expected address is start+i (mod DEPTH for feature)
  task automatic run_load(input int n, input logic [3:0] esel,
                          input bit feat, input int start,
                          input int maxgap);
    logic [63:0] d;
    int a;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        tvalid = 1'b0;
        cyc();
        chk("gap_wr_en", 64'(wr_en), 0);
        chk("gap_tready", 64'(tready), 1);
      end
      d = {$urandom, $urandom};
      a = feat ? (start + i) % DEPTH : start + i;
      tvalid = 1'b1;
      tdata = d;
      tkeep = 8'hFF;
      tlast = (i == n - 1);
      cyc();
      tvalid = 1'b0;
      tlast = 1'b0;
      chk("ld_wr_en", 64'(wr_en), 1);
      chk("ld_wr_sel", 64'(wr_sel), 64'(esel));
      chk("ld_wr_addr", 64'(wr_addr), 64'(a));
      chk("ld_wr_data", wr_data, d);
      chk("ld_finish", 64'(task_finish), 64'(i == n - 1));
    end
    cyc();
    chk("ld_end_finish", 64'(task_finish), 0);
    chk("ld_end_tready", 64'(tready), 0);
    chk("ld_end_wr_en", 64'(wr_en), 0);
  endtask

  task automatic run_eng(input bit is_conv, input int delay,
                         input bit inject);
    pulse(is_conv ? 32'h4 : 32'h2);
    chk("eng_conv_start", 64'(conv_start), 64'(is_conv));
    chk("eng_rx_start", 64'(rx_start), 64'(!is_conv));
    chk("eng_tready", 64'(tready), 0);
    for (int k = 0; k < delay; k++) begin
      if (inject && k == 0) reg0 = 32'h11;
      cyc();
      reg0 = '0;
      chk("hold_start", 64'(conv_start | rx_start), 0);
      chk("hold_finish", 64'(task_finish), 0);
      chk("hold_tready", 64'(tready), 0);
    end
    if (is_conv) conv_done = 1'b1;
    else rx_done = 1'b1;
    cyc();
    conv_done = 1'b0;
    rx_done = 1'b0;
    chk("eng_finish", 64'(task_finish), 1);
    cyc();
    chk("eng_finish_end", 64'(task_finish), 0);
    chk("eng_idle_tready", 64'(tready), 0);
  endtask

  initial begin
    int kind, t, n, start;
    bit bank, app, fin;
    logic [7:0] rows;
    logic [3:0] code, esel;
    logic [31:0] r0;
    logic [63:0] da, db;

    tab[0] = '{32'h21, 32'h001, 4, 4'b0001, 2048, 1'b0};
    tab[1] = '{32'h21, 32'h100, 2, 4'b0001, 0, 1'b0};
    tab[2] = '{32'h11, 32'h100, 3, 4'b0100, 2048, 1'b0};
    tab[3] = '{32'h11, 32'h001, 2, 4'b0100, 0, 1'b0};
    tab[4] = '{32'h31, 32'h101, 2, 4'b0010, 0, 1'b0};
    tab[5] = '{32'h81, 32'h101, 3, 4'b1000, 0, 1'b0};
    tab[6] = '{32'h51, 32'h0, 0, 4'b0000, 0, 1'b1};
    tab[7] = '{32'h01, 32'h0, 0, 4'b0000, 0, 1'b1};
    tab[8] = '{32'hF1, 32'h0, 0, 4'b0000, 0, 1'b1};

    s_rst = 1'b1;
    reg0 = '0;
    reg1 = '0;
    tdata = '0;
    tkeep = 8'hFF;
    tvalid = 1'b0;
    tlast = 1'b0;
    conv_done = 1'b0;
    rx_done = 1'b0;
    cyc();

    for (int i = 0; i < 9; i++) begin
      do_reset();
      reg1 = tab[i].r1;
      pulse(tab[i].r0);
      if (tab[i].err) begin
        chk("err_finish", 64'(task_finish), 1);
        chk("err_wr_en", 64'(wr_en), 0);
        chk("err_flag", 64'(cmd_err), 1);
        chk("err_tready", 64'(tready), 0);
        repeat (3) begin
          cyc();
          chk("err_hold", 64'(cmd_err), 1);
          chk("err_no_wr", 64'(wr_en), 0);
          chk("err_one_finish", 64'(task_finish), 0);
        end
      end else begin
        chk("vec_tready", 64'(tready), 1);
        run_load(tab[i].beats, tab[i].sel, tab[i].sel[3],
                 tab[i].base, 1);
        chk("vec_err", 64'(cmd_err), 0);
      end
    end

    do_reset();
    pulse(32'h101181);
    run_load(3, 4'b1000, 1'b1, 0, 0);
    pulse(32'h101381);
    run_load(2, 4'b1000, 1'b1, 3, 0);
    chk("app_rows", 64'(conv_rows), 64'h10);
    chk("app_final", 64'(conv_final), 0);

    do_reset();
    pulse(32'h81);
    run_load(2048, 4'b1000, 1'b1, 0, 0);
    pulse(32'h281);
    run_load(2050, 4'b1000, 1'b1, 2048, 0);
    chk("wrap_err", 64'(cmd_err), 0);

    do_reset();
    run_eng(1'b1, 20, 1'b1);
    run_eng(1'b0, 20, 1'b1);
    run_eng(1'b1, 0, 1'b0);

    do_reset();
    pulse(32'h27);
    chk("prio_tready", 64'(tready), 1);
    chk("prio_conv", 64'(conv_start), 0);
    chk("prio_rx", 64'(rx_start), 0);
    run_load(1, 4'b0001, 1'b0, 0, 0);
    chk("prio_no_conv", 64'(conv_start), 0);
    pulse(32'h6);
    chk("prio2_conv", 64'(conv_start), 1);
    chk("prio2_rx", 64'(rx_start), 0);
    conv_done = 1'b1;
    cyc();
    conv_done = 1'b0;
    chk("prio2_finish", 64'(task_finish), 1);
    cyc();
    chk("prio2_rx_late", 64'(rx_start), 0);

    do_reset();
    reg1 = '0;
    pulse(32'h11);
    tvalid = 1'b1;
    tlast = 1'b0;
    tdata = 64'hA5A5;
    cyc();
    cyc();
    chk("mid_wr_en", 64'(wr_en), 1);
    chk("mid_addr", 64'(wr_addr), 1);
    s_rst = 1'b1;
    cyc();
    chk_zero("mid_rst");
    s_rst = 1'b0;
    tvalid = 1'b0;
    repeat (3) begin
      cyc();
      chk("mid_no_finish", 64'(task_finish), 0);
      chk("mid_idle_tready", 64'(tready), 0);
    end
    pulse(32'h11);
    run_load(2, 4'b0100, 1'b0, 0, 0);

    do_reset();
    pulse(32'h31);
    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    tvalid = 1'b1;
    tkeep = 8'h0F;
    tdata = da;
    cyc();
`ifdef DISPATCH_TKEEP_CHECK_EN
    chk("keep_wr_en", 64'(wr_en), 0);
    chk("keep_err", 64'(cmd_err), 1);
`else
    chk("keep_wr_en", 64'(wr_en), 1);
    chk("keep_data", wr_data, da);
    chk("keep_err", 64'(cmd_err), 0);
`endif
    tkeep = 8'hFF;
    tdata = db;
    tlast = 1'b1;
    cyc();
    tvalid = 1'b0;
    tlast = 1'b0;
    chk("keep2_wr_en", 64'(wr_en), 1);
    chk("keep2_data", wr_data, db);
    chk("keep2_finish", 64'(task_finish), 1);
`ifdef DISPATCH_TKEEP_CHECK_EN
    chk("keep2_addr", 64'(wr_addr), 0);
`else
    chk("keep2_addr", 64'(wr_addr), 1);
`endif
    cyc();

    do_reset();
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        tvalid = 1'b1;
        tdata = {$urandom, $urandom};
        tlast = $urandom_range(0, 1) == 1;
        cyc();
        tvalid = 1'b0;
        tlast = 1'b0;
        chk("stray_tready", 64'(tready), 0);
        chk("stray_wr_en", 64'(wr_en), 0);
      end
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        t = $urandom_range(0, 3);
        bank = $urandom_range(0, 1) == 1;
        n = $urandom_range(1, 6);
        rows = 8'($urandom);
        app = $urandom_range(0, 1) == 1;
        fin = $urandom_range(0, 1) == 1;
        reg1 = $urandom;
        start = 0;
        case (t)
          0: begin
            code = 4'd1; esel = 4'b0100;
            reg1[8] = bank;
            start = bank ? 2048 : 0;
          end
          1: begin
            code = 4'd2; esel = 4'b0001;
            reg1[0] = bank;
            start = bank ? 2048 : 0;
          end
          2: begin
            code = 4'd3; esel = 4'b0010;
          end
          default: begin
            code = 4'd8; esel = 4'b1000;
            start = app ? feat_next : 0;
            feat_next = (start + n) % DEPTH;
            rows_m = int'(rows);
            final_m = int'(fin);
          end
        endcase
        r0 = {8'h0, rows, 5'b0, fin, app, 1'b0, code, 4'b0001};
        pulse(r0);
        chk("rnd_tready", 64'(tready), 1);
        run_load(n, esel, t == 3, start, 2);
      end else begin
        run_eng(kind == 1, $urandom_range(0, 5),
                $urandom_range(0, 1) == 1);
      end
      chk("rnd_rows", 64'(conv_rows), 64'(rows_m));
      chk("rnd_final", 64'(conv_final), 64'(final_m));
      chk("rnd_err", 64'(cmd_err), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/layer_cmd_dispatch.md
# layer_cmd_dispatch

Accelerator-side command dispatcher sitting directly downstream of the PS/testbench DMA MM2S stream and AXI-Lite register bank. Decodes `slave_lite_reg0` commands, steers incoming 64-bit stream beats into the bias, LeakyReLU, weight or feature buffers, and launches the convolution and S2MM result-readback engines. Emits one `task_finish` pulse per completed command, which the host side uses to sequence the layer.

## Interface
Parameters:
- `ADDR_W`, 12: buffer write-address width.
- `FEATURE_DEPTH`, 4096: feature buffer depth in 64-bit words; the feature address wraps here.

Ports:
- `sclk`  in  1  system clock.
- `s_rst`  in  1  reset, synchronous, active-high.
- `slave_lite_reg0`  in  32  command register: [0] load, [1] rx, [2] conv, [7:4] load target, [9] feature append, [10] feature final, [23:16] feature row count.
- `slave_lite_reg1`  in  32  bank select: [0] bias bank, [8] weight bank.
- `s_axis_mm2s_tdata`  in  64  stream data.
- `s_axis_mm2s_tkeep`  in  8  byte enables.
- `s_axis_mm2s_tvalid`  in  1  beat valid.
- `s_axis_mm2s_tready`  out  1  beat accept.
- `s_axis_mm2s_tlast`  in  1  last beat of the load.
- `wr_en`  out  1  buffer write strobe.
- `wr_sel`  out  4  one-hot buffer select: [0] bias, [1] leakyrelu, [2] weight, [3] feature.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  64  write data.
- `conv_start` / `rx_start`  out  1  one-cycle launch pulses.
- `conv_rows`  out  8  latched reg0[23:16].
- `conv_final`  out  1  latched reg0[10].
- `conv_done` / `rx_done`  in  1  engine completion pulses.
- `task_finish`  out  1  one-cycle completion pulse.
- `cmd_err`  out  1  sticky error flag; cleared only by reset.

## Operation
- Command bits reg0[2:0] are rising-edge detected against a registered copy. The host holds a bit for at least 1 cycle and then clears it.
- Load target decode from reg0[7:4]:
  - 1: weight, with bank reg1[8] as the address MSB.
  - 2: bias, with bank reg1[0] as the address MSB.
  - 3: leakyrelu.
  - 8: feature.
  - Any other value: set `cmd_err` and pulse `task_finish` on the next cycle, with no writes.
- FSM states:
  - IDLE:
    - A load edge goes to LOAD.
    - Otherwise a conv edge goes to CONV.
    - Otherwise an rx edge goes to RX.
    - Priority is load > conv > rx. Lower-priority edges arriving in the same cycle are discarded.
  - LOAD:
    - `tready`=1.
    - Each handshake (`tvalid`&`tready`) writes one word: `wr_en`=1, data and select registered.
    - Address increments after each write.
    - A handshake with `tlast` goes to DONE.
  - CONV: `conv_start` pulses on entry. Waits for `conv_done`, then goes to DONE.
  - RX: `rx_start` pulses on entry. Waits for `rx_done`, then goes to DONE.
  - DONE: `task_finish`=1 for one cycle, then returns to IDLE.
- Address reset on load start:
  - Bias, leakyrelu and weight restart at offset 0.
  - Feature restarts at 0 unless reg0[9]=1 (append), in which case it continues from the last feature address.
  - The feature address wraps from FEATURE_DEPTH-1 to 0.
- `conv_rows` and `conv_final` are latched on a feature load start.
- Command edges arriving outside IDLE are ignored (consumed), with no error.
- `tready`=0 outside LOAD. A stray beat outside LOAD is not accepted.
- Reset mid-operation: state returns to IDLE, all outputs drop to 0, the feature address clears, and no `task_finish` is issued.

## Timing
- Reset values are 0 for: `s_axis_mm2s_tready`, `wr_en`, `wr_sel`, `wr_addr`, `wr_data`, `conv_start`, `rx_start`, `conv_rows`, `conv_final`, `task_finish`, `cmd_err`. The registered command copy and the feature address are also 0.
- Command edge to LOAD/CONV/RX entry: 1 cycle after the reg0 edge is sampled.
- `conv_start`/`rx_start` assert in the first cycle of CONV/RX.
- Write latency: `wr_*` is valid 1 cycle after the handshake.
- `task_finish` timing:
  - Loads: 1 cycle after the `tlast` handshake, aligned with the final `wr_en`.
  - Conv/RX: 1 cycle after the `*_done` pulse.
- `tready` is combinational from state only, so the stream is back-to-back capable at 1 beat/cycle.
- A `conv_done` arriving in the same cycle as `conv_start` is honoured.

## Configuration
- `DISPATCH_TKEEP_CHECK_EN`:
  - Defined: in LOAD, a beat with `tkeep`≠8'hFF is accepted but not written, the address does not advance, and `cmd_err` is set. `tlast` on such a beat still terminates the load.
  - Undefined: `tkeep` is ignored and every accepted beat is written.

## Test plan
- Bias load: reg0=0x21 then 0x20, reg1 bit0=1, 4 beats with `tlast` on the 4th. Expect `wr_sel`=0001, addresses {1,0x000}..{1,0x003}, and one `task_finish` 1 cycle after the last handshake.
- Feature append: first load reg0=0x101181 with 3 beats, then reg0=0x101381 with 2 beats. Expect feature addresses 0,1,2 and then 3,4. `conv_rows`=0x10, `conv_final`=0.
- Wrap: append loads totalling FEATURE_DEPTH+2 beats. Expect the last two writes at addresses 0 and 1, with no `cmd_err`.
- Conv/RX handshake: reg0 bit2 edge gives `conv_start` for 1 cycle. Hold off 20 cycles, then pulse `conv_done`; expect `task_finish` exactly 1 cycle later. Repeat with bit1/`rx_done`. Issue a load edge during CONV; expect it ignored.
- Errors:
  - reg0=0x51 (bad target): `task_finish` with no `wr_en`, and `cmd_err`=1 held until reset.
  - With `DISPATCH_TKEEP_CHECK_EN`, a beat with tkeep=0x0F is not written and `cmd_err`=1.
- Reset 2 beats into a weight load: all outputs return to 0 next cycle, and a new 0x11 load restarts at address 0.
